// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and default widths shared by the GPIO controller files.
package gpio_pkg;
  localparam int GPIO_DATA_W = 8;
  localparam int GPIO_ADDR_W = 3;
  localparam int GPIO_NUM_DEFAULT = 8;
  localparam int GPIO_DEBOUNCE_DEFAULT = 16;
  typedef enum logic [GPIO_ADDR_W-1:0] {
    GPIO_ADDR_DATA_OUT   = 3'd0,
    GPIO_ADDR_OE         = 3'd1,
    GPIO_ADDR_DATA_IN    = 3'd2,
    GPIO_ADDR_IRQ_EN     = 3'd3,
    GPIO_ADDR_IRQ_STATUS = 3'd4,
    GPIO_ADDR_EDGE_SEL   = 3'd5,
    GPIO_ADDR_EDGE_BOTH  = 3'd6,
    GPIO_ADDR_RSVD       = 3'd7
  } gpio_addr_e;
endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: per-pin 2-flop pad synchronizer, edge history and rise/fall pulses.
// Optional per-pin debounce counters when GPIO_DEBOUNCE_EN is defined.
module gpio_in_sync #(
  parameter int W = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [W-1:0] pad_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] sync1_q, sync2_q, hist_q, level;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [W-1:0] deb_q, deb_d, done;
  // A pin's counter runs only while the synchronized level differs from the accepted one
  for (genvar i = 0; i < W; i++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    assign done[i] = (sync2_q[i] != deb_q[i]) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign cnt_d = (sync2_q[i] == deb_q[i] || done[i]) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge sys_clk) cnt_q <= sys_rst ? '0 : cnt_d;
  end
  assign deb_d = deb_q ^ done;
  always_ff @(posedge sys_clk) deb_q <= sys_rst ? '0 : deb_d;
  assign level = deb_q;
`else
  assign level = sync2_q;
`endif
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      hist_q  <= level;
    end
  end
  assign level_o = level;
  assign rise_o  = level & ~hist_q;
  assign fall_o  = ~level & hist_q;
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO pad controller with edge interrupts.
// Define GPIO_DEBOUNCE_EN to insert per-pin input debounce ahead of DATA_IN/edge logic.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_GPIO = GPIO_NUM_DEFAULT,
  parameter int ADDR_W = GPIO_ADDR_W,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [ADDR_W-1:0]   reg_addr,
  input  logic                reg_wr_en,
  input  logic [7:0]          reg_wdata,
  input  logic                reg_rd_en,
  output logic [7:0]          reg_rdata,
  output logic                reg_rd_valid,
  output logic [NUM_GPIO-1:0] gpio_data_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  input  logic [NUM_GPIO-1:0] gpio_data_in,
  output logic                irq
);
  localparam logic [ADDR_W-1:0] A_DO = ADDR_W'(GPIO_ADDR_DATA_OUT);
  localparam logic [ADDR_W-1:0] A_OE = ADDR_W'(GPIO_ADDR_OE);
  localparam logic [ADDR_W-1:0] A_DI = ADDR_W'(GPIO_ADDR_DATA_IN);
  localparam logic [ADDR_W-1:0] A_IE = ADDR_W'(GPIO_ADDR_IRQ_EN);
  localparam logic [ADDR_W-1:0] A_IS = ADDR_W'(GPIO_ADDR_IRQ_STATUS);
  localparam logic [ADDR_W-1:0] A_ES = ADDR_W'(GPIO_ADDR_EDGE_SEL);
  localparam logic [ADDR_W-1:0] A_EB = ADDR_W'(GPIO_ADDR_EDGE_BOTH);
  logic [NUM_GPIO-1:0] data_out_q, data_out_d, oe_q, oe_d, irq_en_q, irq_en_d;
  logic [NUM_GPIO-1:0] status_q, status_d, edge_sel_q, edge_sel_d, edge_both_q, edge_both_d;
  logic [NUM_GPIO-1:0] level, rise, fall, ev, wmask, rd_raw;
  logic [7:0]          rdata_q, rdata_d;
  logic                rd_valid_q, irq_q, irq_d;
  gpio_in_sync #(.W(NUM_GPIO), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .pad_i   (gpio_data_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );
  assign wmask = reg_wdata[NUM_GPIO-1:0];
  always_comb begin
    data_out_d  = (reg_wr_en && reg_addr == A_DO) ? wmask : data_out_q;
    oe_d        = (reg_wr_en && reg_addr == A_OE) ? wmask : oe_q;
    irq_en_d    = (reg_wr_en && reg_addr == A_IE) ? wmask : irq_en_q;
    edge_sel_d  = (reg_wr_en && reg_addr == A_ES) ? wmask : edge_sel_q;
    edge_both_d = (reg_wr_en && reg_addr == A_EB) ? wmask : edge_both_q;
    ev          = (rise & (edge_both_q | edge_sel_q)) | (fall & (edge_both_q | ~edge_sel_q));
    // Edge set is OR-ed after the W1C clear so a coincident event survives
    status_d    = (status_q & ~((reg_wr_en && reg_addr == A_IS) ? wmask : '0)) | ev;
    irq_d       = |(status_q & irq_en_q);
    rd_raw      = reg_addr == A_DO ? data_out_q :
                  reg_addr == A_OE ? oe_q :
                  reg_addr == A_DI ? level :
                  reg_addr == A_IE ? irq_en_q :
                  reg_addr == A_IS ? status_q :
                  reg_addr == A_ES ? edge_sel_q :
                  reg_addr == A_EB ? edge_both_q : '0;
    rdata_d = '0;
    rdata_d[NUM_GPIO-1:0] = reg_rd_en ? rd_raw : '0;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_out_q  <= '0;
      oe_q        <= '0;
      irq_en_q    <= '0;
      status_q    <= '0;
      edge_sel_q  <= '0;
      edge_both_q <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      oe_q        <= oe_d;
      irq_en_q    <= irq_en_d;
      status_q    <= status_d;
      edge_sel_q  <= edge_sel_d;
      edge_both_q <= edge_both_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= reg_rd_en;
      irq_q       <= irq_d;
    end
  end
  assign reg_rdata     = rdata_q;
  assign reg_rd_valid  = rd_valid_q;
  assign gpio_data_out = data_out_q;
  assign gpio_oe       = oe_q;
  assign irq           = irq_q;
endmodule
